// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_pipe.sv
// Pipelined, polarity-programmable inverter bank.
// Each channel of I is XORed with an active polarity mask (bit=1 inverts,
// bit=0 passes) and delivered on ZN after DEPTH register stages. A new mask
// is staged in a shadow register and only made active once the pipeline has
// fully drained, so no output word ever mixes bits from two masks.
module gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_POL = '1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VLD,
    input  logic [WIDTH-1:0] POL,
    input  logic             POL_LD,
    output logic             POL_BUSY,
    output logic [WIDTH-1:0] ZN,
    output logic             ZN_VLD,
    inout  wire              VDD,
    inout  wire              VSS
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY
    } pol_state_e;

    pol_state_e       state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;

    // Per-stage register contents, gathered from the generate blocks below.
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    logic accept;
    logic unused_supply;

    // Supply pins exist for the cell footprint only; they carry no function.
    assign unused_supply = VDD ^ VSS;

    // Inputs are refused for the whole duration of a polarity update.
    assign accept   = I_VLD && (state_q == ST_IDLE);
    assign POL_BUSY = (state_q != ST_IDLE);

    assign ZN     = stage_data[DEPTH-1];
    assign ZN_VLD = stage_vld[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        localparam bit LAST = (k == DEPTH - 1);

        logic [WIDTH-1:0] in_data;
        logic             in_vld;
        logic [WIDTH-1:0] data_q, data_d;
        logic             vld_q, vld_d;

        if (k == 0) begin : g_head
            assign in_data = I;
            assign in_vld  = accept;
        end else begin : g_body
            assign in_data = stage_data[k-1];
            assign in_vld  = stage_vld[k-1];
        end

        // Data only moves on a valid word; the mask is applied as the word
        // enters the last stage so the active mask is sampled exactly once.
        always_comb begin
            // NOTE: every signal assigned in always_comb gets a default first;
            // a missing else-path would otherwise infer a latch.
            data_d = data_q;
            vld_d  = in_vld;
            if (in_vld) begin
                data_d = LAST ? (in_data ^ mask_q) : in_data;
            end
        end

        // Stage register; valid shifts every cycle, data holds when idle.
        always_ff @(posedge CLK or negedge RN) begin
            // NOTE: data registers are reset as well because the last stage
            // is the visible ZN output, which must read zero out of reset.
            if (!RN) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments so all
                // flops sample their inputs from the same pre-edge values.
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign stage_data[k] = data_q;
        assign stage_vld[k]  = vld_q;
    end

    // Polarity update sequencer: capture, wait for an empty pipe, apply.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        unique case (state_q)
            ST_IDLE: begin
                if (POL_LD) begin
                    shadow_d = POL;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (stage_vld == '0) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                mask_d  = shadow_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, active mask and shadow mask.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            mask_q   <= RESET_POL;
            shadow_q <= RESET_POL;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__inv_pipe.sv
// Self-checking bench: three instances (DEPTH 2, 1, 8) share one stimulus
// stream and are scored every cycle against a timeline model that schedules
// each accepted word at its output edge and computes polarity busy windows
// in closed form.
module tb_gf180mcu_fd_sc_mcu9t5v0__inv_pipe;

    localparam int W  = 8;
    localparam int NI = 3;
    localparam int NE = 2048;

    logic         CLK    = 1'b0;
    logic         RN     = 1'b1;
    logic [W-1:0] I      = '0;
    logic [W-1:0] POL    = '0;
    logic         I_VLD  = 1'b0;
    logic         POL_LD = 1'b0;
    wire          VDD;
    wire          VSS;

    assign VDD = 1'b1;
    assign VSS = 1'b0;

    logic [W-1:0] zn     [NI];
    logic         zn_vld [NI];
    logic         busy   [NI];

    gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(.WIDTH(W), .DEPTH(2), .RESET_POL(8'hFF)) dut_d2 (
        .CLK(CLK), .RN(RN), .I(I), .I_VLD(I_VLD), .POL(POL), .POL_LD(POL_LD),
        .POL_BUSY(busy[0]), .ZN(zn[0]), .ZN_VLD(zn_vld[0]), .VDD(VDD), .VSS(VSS));

    gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(.WIDTH(W), .DEPTH(1), .RESET_POL(8'hFF)) dut_d1 (
        .CLK(CLK), .RN(RN), .I(I), .I_VLD(I_VLD), .POL(POL), .POL_LD(POL_LD),
        .POL_BUSY(busy[1]), .ZN(zn[1]), .ZN_VLD(zn_vld[1]), .VDD(VDD), .VSS(VSS));

    gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(.WIDTH(W), .DEPTH(8), .RESET_POL(8'hFF)) dut_d8 (
        .CLK(CLK), .RN(RN), .I(I), .I_VLD(I_VLD), .POL(POL), .POL_LD(POL_LD),
        .POL_BUSY(busy[2]), .ZN(zn[2]), .ZN_VLD(zn_vld[2]), .VDD(VDD), .VSS(VSS));

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    int           e        = 0;   // index of the next rising edge
    bit           m_pend     [NI];
    int           m_from     [NI];
    int           m_end      [NI];
    int           m_last_acc [NI];
    logic [W-1:0] m_mask     [NI];
    logic [W-1:0] m_shadow   [NI];
    logic [W-1:0] m_zn       [NI];
    bit           exp_vld    [NI][NE];
    logic [W-1:0] exp_val    [NI][NE];

    function automatic int dep_of(input int j);
        case (j)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NI; j++) begin
            m_pend[j]     = 1'b0;
            m_mask[j]     = 8'hFF;
            m_shadow[j]   = 8'hFF;
            m_zn[j]       = '0;
            m_last_acc[j] = -100;
            for (int k = e; k < NE; k++) exp_vld[j][k] = 1'b0;
        end
    endtask

    // Apply the inputs present before edge e to the timeline model.
    task automatic model_edge();
        for (int j = 0; j < NI; j++) begin
            bit busy_pre;
            int d;
            int dep;
            dep      = dep_of(j);
            busy_pre = m_pend[j] && (e > m_from[j]);
            if (m_pend[j] && e == m_end[j]) begin
                m_mask[j] = m_shadow[j];
                m_pend[j] = 1'b0;
            end
            if (I_VLD && !busy_pre) begin
                if (e + dep - 1 < NE) begin
                    exp_vld[j][e+dep-1] = 1'b1;
                    exp_val[j][e+dep-1] = I ^ m_mask[j];
                end
                m_last_acc[j] = e;
            end
            if (POL_LD && !busy_pre) begin
                // Drain ends on the first edge with no word inside the pipe;
                // the mask switches one edge after that.
                m_pend[j]   = 1'b1;
                m_from[j]   = e;
                m_shadow[j] = POL;
                d = (e + 1 > m_last_acc[j] + dep + 1) ? e + 1 : m_last_acc[j] + dep + 1;
                m_end[j]    = d + 1;
            end
        end
    endtask

    // One clock cycle: advance model, clock, score every instance.
    task automatic tick();
        if (RN === 1'b1) model_edge();
        @(posedge CLK);
        #1;
        for (int j = 0; j < NI; j++) begin
            if (exp_vld[j][e]) m_zn[j] = exp_val[j][e];
            n_checks++;
            if (zn_vld[j] !== exp_vld[j][e])
                $display("FAIL sb_zn_vld inst%0d edge%0d: got %b want %b", j, e, zn_vld[j], exp_vld[j][e]);
            else n_pass++;
            n_checks++;
            if (zn[j] !== m_zn[j])
                $display("FAIL sb_zn inst%0d edge%0d: got %h want %h", j, e, zn[j], m_zn[j]);
            else n_pass++;
            n_checks++;
            if (busy[j] !== m_pend[j])
                $display("FAIL sb_busy inst%0d edge%0d: got %b want %b", j, e, busy[j], m_pend[j]);
            else n_pass++;
        end
        e++;
    endtask

    task automatic settle();
        I_VLD  = 1'b0;
        POL_LD = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        RN = 1'b0;
        #1;
        model_reset();
        for (int j = 0; j < NI; j++) begin
            n_checks++;
            if (zn[j] !== 8'h00 || zn_vld[j] !== 1'b0 || busy[j] !== 1'b0)
                $display("FAIL reset_state inst%0d: got zn=%h vld=%b busy=%b want 00/0/0", j, zn[j], zn_vld[j], busy[j]);
            else n_pass++;
        end
        tick();
        tick();
        RN = 1'b1;
    endtask

    task automatic test_single();
        I = 8'h5A; I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0; I = 8'h00;
        n_checks++;
        if (zn_vld[0] !== 1'b0) $display("FAIL single_early: got vld=%b want 0", zn_vld[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (zn[0] !== 8'hA5 || zn_vld[0] !== 1'b1)
            $display("FAIL single_out: got zn=%h vld=%b want a5/1", zn[0], zn_vld[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (zn[0] !== 8'hA5 || zn_vld[0] !== 1'b0)
            $display("FAIL single_hold: got zn=%h vld=%b want a5/0", zn[0], zn_vld[0]);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [W-1:0] sv [3];
        sv[0] = 8'h00; sv[1] = 8'hFF; sv[2] = 8'h0F;
        for (int k = 0; k < 5; k++) begin
            I_VLD = (k < 3);
            I     = (k < 3) ? sv[k] : 8'h00;
            tick();
            if (k >= 1 && k <= 3) begin
                n_checks++;
                if (zn[0] !== (sv[k-1] ^ 8'hFF) || zn_vld[0] !== 1'b1)
                    $display("FAIL stream_%0d: got zn=%h vld=%b want %h/1", k - 1, zn[0], zn_vld[0], sv[k-1] ^ 8'hFF);
                else n_pass++;
            end else if (k == 4) begin
                n_checks++;
                if (zn_vld[0] !== 1'b0 || zn[0] !== 8'hF0)
                    $display("FAIL stream_end: got zn=%h vld=%b want f0/0", zn[0], zn_vld[0]);
                else n_pass++;
            end
        end
        I_VLD = 1'b0;
    endtask

    task automatic test_pol_change();
        int busy_cnt;
        settle();
        busy_cnt = 0;
        I = 8'h33; I_VLD = 1'b1; POL = 8'h0F; POL_LD = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            I_VLD = 1'b0; POL_LD = 1'b0;
            if (busy[0] === 1'b1) busy_cnt++;
            if (k == 1) begin
                n_checks++;
                if (zn[0] !== 8'hCC || zn_vld[0] !== 1'b1)
                    $display("FAIL pol_old_mask: got zn=%h vld=%b want cc/1", zn[0], zn_vld[0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy_cnt != 4) $display("FAIL pol_busy_len: got %0d want 4", busy_cnt);
        else n_pass++;
        I = 8'h33; I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0;
        n_checks++;
        if (zn[1] !== 8'h3C || zn_vld[1] !== 1'b1)
            $display("FAIL pol_new_mask_d1: got zn=%h vld=%b want 3c/1", zn[1], zn_vld[1]);
        else n_pass++;
        tick();
        n_checks++;
        if (zn[0] !== 8'h3C || zn_vld[0] !== 1'b1)
            $display("FAIL pol_new_mask: got zn=%h vld=%b want 3c/1", zn[0], zn_vld[0]);
        else n_pass++;
        settle();
    endtask

    task automatic test_drop();
        logic [W-1:0] prev;
        POL = 8'h0F; POL_LD = 1'b1;
        tick();
        POL_LD = 1'b0;
        prev = zn[0];
        I = 8'h11; I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0;
        tick();
        n_checks++;
        if (zn_vld[0] !== 1'b0 || zn[0] !== prev)
            $display("FAIL drop_busy: got zn=%h vld=%b want %h/0", zn[0], zn_vld[0], prev);
        else n_pass++;
        settle();
    endtask

    task automatic test_reset_mid_drain();
        int vld_seen;
        I = 8'h40; I_VLD = 1'b1;
        tick();
        I = 8'h41; POL = 8'h3C; POL_LD = 1'b1;
        tick();
        I_VLD = 1'b0; POL_LD = 1'b0;
        RN = 1'b0;
        #1;
        model_reset();
        for (int j = 0; j < NI; j++) begin
            n_checks++;
            if (zn[j] !== 8'h00 || zn_vld[j] !== 1'b0 || busy[j] !== 1'b0)
                $display("FAIL reset_drain inst%0d: got zn=%h vld=%b busy=%b want 00/0/0", j, zn[j], zn_vld[j], busy[j]);
            else n_pass++;
        end
        tick();
        RN = 1'b1;
        vld_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (zn_vld[0] === 1'b1) vld_seen++;
        end
        n_checks++;
        if (vld_seen != 0) $display("FAIL reset_no_output: got %0d pulses want 0", vld_seen);
        else n_pass++;
        I = 8'h01; I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0;
        tick();
        n_checks++;
        if (zn[0] !== 8'hFE || zn_vld[0] !== 1'b1)
            $display("FAIL reset_mask: got zn=%h vld=%b want fe/1", zn[0], zn_vld[0]);
        else n_pass++;
        settle();
    endtask

    task automatic test_depth_sweep();
        int first [NI];
        int cnt   [NI];
        int bcnt  [NI];
        int e0;
        for (int j = 0; j < NI; j++) begin first[j] = -1; cnt[j] = 0; bcnt[j] = 0; end
        e0 = e;
        for (int k = 0; k < 24; k++) begin
            I_VLD  = (k < 10);
            I      = 8'($urandom);
            POL    = 8'($urandom);
            POL_LD = (k == 9);
            tick();
            for (int j = 0; j < NI; j++) begin
                if (zn_vld[j] === 1'b1) begin
                    if (first[j] < 0) first[j] = e - 1;
                    cnt[j]++;
                end
                if (busy[j] === 1'b1) bcnt[j]++;
            end
        end
        I_VLD = 1'b0; POL_LD = 1'b0;
        for (int j = 0; j < NI; j++) begin
            n_checks++;
            if (first[j] - e0 != dep_of(j) - 1)
                $display("FAIL sweep_latency inst%0d: got %0d want %0d", j, first[j] - e0, dep_of(j) - 1);
            else n_pass++;
            n_checks++;
            if (cnt[j] != 10) $display("FAIL sweep_throughput inst%0d: got %0d want 10", j, cnt[j]);
            else n_pass++;
            n_checks++;
            if (bcnt[j] != dep_of(j) + 2)
                $display("FAIL sweep_drain inst%0d: got %0d want %0d", j, bcnt[j], dep_of(j) + 2);
            else n_pass++;
        end
        settle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            I      = 8'($urandom);
            POL    = 8'($urandom);
            I_VLD  = ($urandom_range(0, 9) < 7);
            POL_LD = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                RN = 1'b0;
                #1;
                model_reset();
                for (int j = 0; j < NI; j++) begin
                    n_checks++;
                    if (zn[j] !== 8'h00 || zn_vld[j] !== 1'b0 || busy[j] !== 1'b0)
                        $display("FAIL rand_reset inst%0d: got zn=%h vld=%b busy=%b want 00/0/0", j, zn[j], zn_vld[j], busy[j]);
                    else n_pass++;
                end
                tick();
                RN = 1'b1;
            end else begin
                tick();
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_pol_change();
        test_drop();
        test_reset_mid_drain();
        test_depth_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
